// File: rtl/alu_rs.sv
// ALU reservation station: buffers ALU/branch/jump ops until operands are known, issues one per cycle.
// Optional macro RS_OLDEST_FIRST_EN selects oldest-ready issue instead of lowest-index-ready.
module alu_rs #(
    parameter int RS_SIZE     = 16,
    parameter int RS_IDX_BITS = 4,
    parameter int ROB_ID_WID  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic                  in_valid,
    input  logic [6:0]            in_opcode,
    input  logic [2:0]            in_func3,
    input  logic                  in_func1,
    input  logic                  in_qj_wait,
    input  logic [ROB_ID_WID-1:0] in_qj,
    input  logic [31:0]           in_vj,
    input  logic                  in_qk_wait,
    input  logic [ROB_ID_WID-1:0] in_qk,
    input  logic [31:0]           in_vk,
    input  logic [31:0]           in_imm,
    input  logic [31:0]           in_off,
    input  logic [31:0]           in_pc,
    input  logic [ROB_ID_WID-1:0] in_rob_target,
    input  logic                  in_is_c_extend,
    output logic                  rs_full,
    input  logic                  alu_cdb_valid,
    input  logic [ROB_ID_WID-1:0] alu_cdb_rob,
    input  logic [31:0]           alu_cdb_data,
    input  logic                  lsb_cdb_valid,
    input  logic [ROB_ID_WID-1:0] lsb_cdb_rob,
    input  logic [31:0]           lsb_cdb_data,
    output logic                  alu_inst_valid,
    output logic [6:0]            alu_opcode,
    output logic [2:0]            alu_func3,
    output logic                  alu_func1,
    output logic [31:0]           alu_data1,
    output logic [31:0]           alu_data2,
    output logic [31:0]           alu_imm,
    output logic [31:0]           alu_off,
    output logic [31:0]           alu_pc,
    output logic [ROB_ID_WID-1:0] alu_rob_target,
    output logic                  alu_is_c_extend
);

    logic [RS_SIZE-1:0]    busy;
    logic [RS_SIZE-1:0]    qj_wait;
    logic [RS_SIZE-1:0]    qk_wait;
    logic [RS_SIZE-1:0]    e_func1;
    logic [RS_SIZE-1:0]    e_is_c;
    logic [ROB_ID_WID-1:0] e_qj  [RS_SIZE];
    logic [ROB_ID_WID-1:0] e_qk  [RS_SIZE];
    logic [ROB_ID_WID-1:0] e_rob [RS_SIZE];
    logic [31:0]           e_vj  [RS_SIZE];
    logic [31:0]           e_vk  [RS_SIZE];
    logic [31:0]           e_imm [RS_SIZE];
    logic [31:0]           e_off [RS_SIZE];
    logic [31:0]           e_pc  [RS_SIZE];
    logic [6:0]            e_op  [RS_SIZE];
    logic [2:0]            e_f3  [RS_SIZE];

    logic [RS_SIZE-1:0]    ready;
    logic [RS_SIZE-1:0]    cand;
    logic                  free_found;
    logic [RS_IDX_BITS-1:0] free_idx;
    logic                  iss_found;
    logic [RS_IDX_BITS-1:0] iss_idx;
    logic                  do_insert;
    logic                  new_jw;
    logic                  new_kw;
    logic [31:0]           new_vj;
    logic [31:0]           new_vk;

    assign rs_full   = &busy;
    assign ready     = busy & ~qj_wait & ~qk_wait;
    assign do_insert = in_valid && !rs_full;

`ifdef RS_OLDEST_FIRST_EN
    // older[i][j] set means entry j was dispatched before entry i
    logic [RS_SIZE-1:0] older [RS_SIZE];

    // An entry is a candidate only if no older entry is also ready
    always_comb begin
        cand = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            cand[i] = ready[i] && !(|(older[i] & ready));
        end
    end

    // Record relative age at dispatch; cleared on reset and flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
        end else if (rollback) begin
            for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
        end else if (rdy && do_insert) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (free_idx == RS_IDX_BITS'(i)) older[i] <= busy;
                else older[i][free_idx] <= 1'b0;
            end
        end
    end
`else
    assign cand = ready;
`endif

    // Lowest-index free slot for dispatch
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = RS_IDX_BITS'(i);
            end
        end
    end

    // Lowest-index issue candidate
    always_comb begin
        iss_found = 1'b0;
        iss_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (cand[i] && !iss_found) begin
                iss_found = 1'b1;
                iss_idx   = RS_IDX_BITS'(i);
            end
        end
    end

    // Incoming operands can be resolved by a same-cycle broadcast
    always_comb begin
        new_jw = in_qj_wait;
        new_vj = in_vj;
        new_kw = in_qk_wait;
        new_vk = in_vk;
        if (in_qj_wait) begin
            if (alu_cdb_valid && alu_cdb_rob == in_qj) begin
                new_jw = 1'b0;
                new_vj = alu_cdb_data;
            end else if (lsb_cdb_valid && lsb_cdb_rob == in_qj) begin
                new_jw = 1'b0;
                new_vj = lsb_cdb_data;
            end
        end
        if (in_qk_wait) begin
            if (alu_cdb_valid && alu_cdb_rob == in_qk) begin
                new_kw = 1'b0;
                new_vk = alu_cdb_data;
            end else if (lsb_cdb_valid && lsb_cdb_rob == in_qk) begin
                new_kw = 1'b0;
                new_vk = lsb_cdb_data;
            end
        end
    end

    // Entry storage: wakeup, issue release and dispatch insert
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            qj_wait <= '0;
            qk_wait <= '0;
            e_func1 <= '0;
            e_is_c  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                e_qj[i]  <= '0;
                e_qk[i]  <= '0;
                e_rob[i] <= '0;
                e_vj[i]  <= '0;
                e_vk[i]  <= '0;
                e_imm[i] <= '0;
                e_off[i] <= '0;
                e_pc[i]  <= '0;
                e_op[i]  <= '0;
                e_f3[i]  <= '0;
            end
        end else if (rollback) begin
            busy <= '0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && qj_wait[i]) begin
                    if (alu_cdb_valid && alu_cdb_rob == e_qj[i]) begin
                        e_vj[i]    <= alu_cdb_data;
                        qj_wait[i] <= 1'b0;
                    end else if (lsb_cdb_valid && lsb_cdb_rob == e_qj[i]) begin
                        e_vj[i]    <= lsb_cdb_data;
                        qj_wait[i] <= 1'b0;
                    end
                end
                if (busy[i] && qk_wait[i]) begin
                    if (alu_cdb_valid && alu_cdb_rob == e_qk[i]) begin
                        e_vk[i]    <= alu_cdb_data;
                        qk_wait[i] <= 1'b0;
                    end else if (lsb_cdb_valid && lsb_cdb_rob == e_qk[i]) begin
                        e_vk[i]    <= lsb_cdb_data;
                        qk_wait[i] <= 1'b0;
                    end
                end
            end
            if (iss_found) busy[iss_idx] <= 1'b0;
            if (do_insert) begin
                busy[free_idx]    <= 1'b1;
                qj_wait[free_idx] <= new_jw;
                qk_wait[free_idx] <= new_kw;
                e_qj[free_idx]    <= in_qj;
                e_qk[free_idx]    <= in_qk;
                e_vj[free_idx]    <= new_vj;
                e_vk[free_idx]    <= new_vk;
                e_rob[free_idx]   <= in_rob_target;
                e_imm[free_idx]   <= in_imm;
                e_off[free_idx]   <= in_off;
                e_pc[free_idx]    <= in_pc;
                e_op[free_idx]    <= in_opcode;
                e_f3[free_idx]    <= in_func3;
                e_func1[free_idx] <= in_func1;
                e_is_c[free_idx]  <= in_is_c_extend;
            end
        end
    end

    // Registered issue port toward the ALU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_inst_valid  <= 1'b0;
            alu_opcode      <= '0;
            alu_func3       <= '0;
            alu_func1       <= 1'b0;
            alu_data1       <= '0;
            alu_data2       <= '0;
            alu_imm         <= '0;
            alu_off         <= '0;
            alu_pc          <= '0;
            alu_rob_target  <= '0;
            alu_is_c_extend <= 1'b0;
        end else if (rollback) begin
            alu_inst_valid <= 1'b0;
        end else if (rdy) begin
            alu_inst_valid <= iss_found;
            if (iss_found) begin
                alu_opcode      <= e_op[iss_idx];
                alu_func3       <= e_f3[iss_idx];
                alu_func1       <= e_func1[iss_idx];
                alu_data1       <= e_vj[iss_idx];
                alu_data2       <= e_vk[iss_idx];
                alu_imm         <= e_imm[iss_idx];
                alu_off         <= e_off[iss_idx];
                alu_pc          <= e_pc[iss_idx];
                alu_rob_target  <= e_rob[iss_idx];
                alu_is_c_extend <= e_is_c[iss_idx];
            end
        end
    end

endmodule
